ex_muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the Execute stage, fed directly by the Decode-to-Execute pipeline register. It executes MULT/MULTU/DIV/DIVU over multiple cycles and MTHI/MTLO in one, and owns the architectural HI/LO registers. A stall request holds the front of the pipeline while a new mul/div, or a HI/LO read, collides with an operation in flight.

---
 rtl/ex_muldiv_unit.sv | 156 +++++++++++++++
 tb/tb_ex_muldiv_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO and MTHI/MTLO.
// Define MULDIV_DIV_EN to build the restoring divider; otherwise DIV/DIVU are no-ops.
module ex_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [2:0]       MulDivOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             HiLoRead,
  input  logic             Flush,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo,
  output logic             Busy,
  output logic             Done,
  output logic             Stall
);
  // state | meaning
  // IDLE  | no operation in flight; MT ops and new mul/div accepted here
  // RUN   | one multiplier/quotient bit per cycle, WIDTH cycles
  // FIX   | sign correction, HI/LO write, Done pulse
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
  localparam int CW = $clog2(WIDTH);

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   acc, step_acc, load_acc, prod;
  logic [WIDTH-1:0]     opnd, load_opnd, a_mag, b_mag, res_hi, res_lo;
  logic [WIDTH:0]       mul_sum;
  logic                 neg_q;
  logic                 op_mult, op_multu, op_mthi, op_mtlo, signed_op, a_neg, b_neg;
  logic                 start_md, start_mt, last_iter;
`ifdef MULDIV_DIV_EN
  logic                 op_div, op_divu, is_div, neg_r, div_zero;
  logic [WIDTH:0]       div_diff;
  assign op_div  = (MulDivOp == 3'b011);
  assign op_divu = (MulDivOp == 3'b100);
`endif

  assign op_mult  = (MulDivOp == 3'b001);
  assign op_multu = (MulDivOp == 3'b010);
  assign op_mthi  = (MulDivOp == 3'b101);
  assign op_mtlo  = (MulDivOp == 3'b110);
`ifdef MULDIV_DIV_EN
  assign signed_op = op_mult | op_div;
  assign start_md  = Start & ~Flush & (op_mult | op_multu | op_div | op_divu);
`else
  assign signed_op = op_mult;
  assign start_md  = Start & ~Flush & (op_mult | op_multu);
`endif
  assign start_mt  = Start & ~Flush & (op_mthi | op_mtlo);
  assign a_neg     = signed_op & A[WIDTH-1];
  assign b_neg     = signed_op & B[WIDTH-1];
  assign a_mag     = a_neg ? -A : A;
  assign b_mag     = b_neg ? -B : B;
  assign last_iter = (cnt == CW'(WIDTH-1));

  // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
  always_comb begin
    load_acc  = {{WIDTH{1'b0}}, b_mag};
    load_opnd = a_mag;
`ifdef MULDIV_DIV_EN
    if (op_div | op_divu) begin
      load_acc  = {{WIDTH{1'b0}}, a_mag};
      load_opnd = b_mag;
    end
`endif
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    step_acc = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    prod     = neg_q ? -acc : acc;
    res_hi   = prod[2*WIDTH-1:WIDTH];
    res_lo   = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
    if (is_div) begin
      step_acc = div_diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      res_lo   = div_zero ? {WIDTH{1'b1}} : (neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
      res_hi   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`endif
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_md) state_nxt = RUN;
      RUN:     if (Flush) state_nxt = IDLE;
               else if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Busy  = (state != IDLE);
    Stall = Busy & (Start | HiLoRead);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Hi    <= '0;
      Lo    <= '0;
      Done  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      neg_q <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div   <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (start_md) begin
            cnt   <= '0;
            acc   <= load_acc;
            opnd  <= load_opnd;
            neg_q <= a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
            is_div   <= op_div | op_divu;
            neg_r    <= a_neg;
            div_zero <= (B == '0);
`endif
          end else if (start_mt) begin
            if (op_mthi) Hi <= A;
            else         Lo <= A;
          end
        end
        RUN: if (!Flush) begin
          cnt <= cnt + 1'b1;
          acc <= step_acc;
        end
        FIX: if (!Flush) begin
          Hi   <= res_hi;
          Lo   <= res_lo;
          Done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed bench for ex_muldiv_unit: arithmetic results, latency, hazards, flush and reset.
module tb_ex_muldiv_unit;
  localparam logic [2:0] OP_MULT = 3'b001, OP_MULTU = 3'b010, OP_DIV = 3'b011,
                         OP_DIVU = 3'b100, OP_MTHI = 3'b101, OP_MTLO = 3'b110;

  logic        Clk = 1'b0, Reset = 1'b0, Start = 1'b0, HiLoRead = 1'b0, Flush = 1'b0;
  logic [2:0]  MulDivOp = 3'b000;
  logic [31:0] A = '0, B = '0;
  logic [31:0] Hi, Lo;
  logic        Busy, Done, Stall;
  int          checks = 0, failures = 0;
  int          lat, bad, seen;

  ex_muldiv_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .MulDivOp(MulDivOp), .A(A), .B(B),
    .HiLoRead(HiLoRead), .Flush(Flush), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done),
    .Stall(Stall)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MulDivOp = op; A = a; B = b;
    @(posedge Clk); #1;
    Start = 1'b0; MulDivOp = 3'b000; A = '0; B = '0;
  endtask

  // Edges counted from the accepting edge until Done is seen; -1 on timeout.
  task automatic wait_done(output int n_out);
    n_out = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Clk); #1;
      if (Done) begin
        n_out = n;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int l;
    issue(op, a, b);
    chk({tag, "_busy"}, Busy, 1'b1);
    wait_done(l);
    chk({tag, "_latency"}, l, 33);
    chk({tag, "_busy_at_done"}, Busy, 1'b0);
    chk({tag, "_hi"}, Hi, exp_hi);
    chk({tag, "_lo"}, Lo, exp_lo);
  endtask

  initial begin
    #1;
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_stall", Stall, 1'b0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    @(posedge Clk); #1;
    chk("done_one_cycle", Done, 1'b0);
    run_op("mult_neg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1);

`ifdef MULDIV_DIV_EN
    run_op("div_neg7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", OP_DIVU, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    run_op("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
`else
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    chk("div_off_busy", Busy, 1'b0);
    seen = 0;
    repeat (36) begin
      @(posedge Clk); #1;
      if (Done) seen++;
    end
    chk("div_off_done", seen, 0);
    chk("div_off_hi", Hi, 32'hFFFF_FFFF);
    chk("div_off_lo", Lo, 32'hFFFF_FFF1);
`endif

    issue(3'b111, 32'h1111_1111, 32'h2222_2222);
    chk("noop_busy", Busy, 1'b0);
    @(posedge Clk); #1;
    chk("noop_busy_later", Busy, 1'b0);

    // Hazard: HI/LO read plus a second mul held behind the first.
    issue(OP_MULT, 32'd2, 32'd3);
    repeat (3) @(posedge Clk);
    #1;
    HiLoRead = 1'b1; Start = 1'b1; MulDivOp = OP_MULTU; A = 32'd10; B = 32'd10;
    #1;
    chk("hazard_stall", Stall, 1'b1);
    seen = 0; bad = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge Clk); #1;
      if (Done) begin
        seen = 1;
        break;
      end
      if (!Stall) bad++;
    end
    chk("hazard_done_seen", seen, 1);
    chk("hazard_stall_gap", bad, 0);
    chk("hazard_stall_at_done", Stall, 1'b0);
    chk("hazard_hi", Hi, 32'h0);
    chk("hazard_lo", Lo, 32'd6);
    @(posedge Clk); #1;
    HiLoRead = 1'b0; Start = 1'b0; MulDivOp = 3'b000; A = '0; B = '0;
    chk("b2b_busy", Busy, 1'b1);
    wait_done(lat);
    chk("b2b_latency", lat, 33);
    chk("b2b_hi", Hi, 32'h0);
    chk("b2b_lo", Lo, 32'd100);

    // Abort in flight after MTHI/MTLO.
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    chk("mthi", Hi, 32'hAAAA_5555);
    issue(OP_MTLO, 32'h5555_AAAA, 32'h0);
    chk("mtlo", Lo, 32'h5555_AAAA);
`ifdef MULDIV_DIV_EN
    issue(OP_DIV, 32'd100, 32'd7);
`else
    issue(OP_MULT, 32'd100, 32'd7);
`endif
    repeat (9) @(posedge Clk);
    #1 Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    chk("flush_idle", Busy, 1'b0);
    seen = 0;
    repeat (36) begin
      @(posedge Clk); #1;
      if (Done) seen++;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_hi", Hi, 32'hAAAA_5555);
    chk("flush_lo", Lo, 32'h5555_AAAA);

    Start = 1'b1; MulDivOp = OP_MULT; A = 32'd3; B = 32'd3; Flush = 1'b1;
    @(posedge Clk); #1;
    chk("flush_start_busy", Busy, 1'b0);
    MulDivOp = OP_MTHI; A = 32'h1234_5678;
    @(posedge Clk); #1;
    Start = 1'b0; Flush = 1'b0; MulDivOp = 3'b000; A = '0; B = '0;
    @(posedge Clk); #1;
    chk("flush_mthi_hi", Hi, 32'hAAAA_5555);

    // Asynchronous reset in the middle of a multiply.
    issue(OP_MULT, 32'd7, 32'd9);
    repeat (19) @(posedge Clk);
    #1 Reset = 1'b0;
    #1;
    chk("arst_hi", Hi, 32'h0);
    chk("arst_lo", Lo, 32'h0);
    chk("arst_busy", Busy, 1'b0);
    chk("arst_done", Done, 1'b0);
    chk("arst_stall", Stall, 1'b0);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;
    run_op("mult_6x7", OP_MULT, 32'd6, 32'd7, 32'h0, 32'd42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
